// File: rtl/ahblite_slave_mux_n.sv
// AHB-Lite data-phase response mux for NPORT slaves, with a built-in default slave that
// answers unmapped or multi-selected transfers with a two-cycle ERROR and counts them.
module ahblite_slave_mux_n #(
  parameter int unsigned NPORT     = 4,
  parameter int unsigned DW        = 32,
  parameter int unsigned CW        = 8,
  parameter bit          MULTI_ERR = 1'b1
) (
  input  logic              HCLK,
  input  logic              HRESETn,
  input  logic              HREADY,
  input  logic [1:0]        HTRANS,
  input  logic [NPORT-1:0]  HSEL,
  input  logic [NPORT-1:0]  P_HREADYOUT,
  input  logic [NPORT-1:0]  P_HRESP,
  input  logic [NPORT*DW-1:0] P_HRDATA,
  input  logic              ERR_CLR,
  output logic              HREADYOUT,
  output logic              HRESP,
  output logic [DW-1:0]     HRDATA,
  output logic [CW-1:0]     ERR_CNT,
  output logic              ERR_IRQ
);

  localparam int unsigned SW = (NPORT > 1) ? $clog2(NPORT) : 1;

  typedef enum logic [1:0] {DpIdle, DpSlave, DpErr1, DpErr2} dp_state_e;

  dp_state_e     state_q, state_d;
  logic [SW-1:0] sel_q, sel_d;
  logic [SW-1:0] low_idx;
  logic          any_sel, multi_sel, hit, sample, err_entry;
  logic          unused_htrans0;

  // Only HTRANS[1] distinguishes a real transfer from IDLE/BUSY.
  assign unused_htrans0 = HTRANS[0];

  always_comb begin
    low_idx = '0;
    for (int k = NPORT - 1; k >= 0; k--) begin
      if (HSEL[k]) low_idx = SW'(k);
    end
    any_sel   = |HSEL;
    multi_sel = (HSEL & (HSEL - NPORT'(1))) != '0;
    hit       = any_sel && (!multi_sel || !MULTI_ERR);
  end

  // A waiting slave blocks sampling even if the bus HREADY is high.
  always_comb begin
    unique case (state_q)
      DpErr1:  sample = 1'b0;
      DpErr2:  sample = 1'b1;
      DpSlave: sample = HREADY && P_HREADYOUT[sel_q];
      default: sample = HREADY;
    endcase
  end

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    if (state_q == DpErr1) begin
      state_d = DpErr2;
    end else if (sample) begin
      if (hit) begin
        state_d = DpSlave;
        sel_d   = low_idx;
      end else if (HTRANS[1]) begin
        state_d = DpErr1;
      end else begin
        state_d = DpIdle;
      end
    end
    err_entry = (state_d == DpErr1);
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q <= DpIdle;
      sel_q   <= '0;
      ERR_IRQ <= 1'b0;
      ERR_CNT <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      ERR_IRQ <= err_entry;
      if (err_entry) begin
        ERR_CNT <= ERR_CLR ? CW'(1) : ((&ERR_CNT) ? ERR_CNT : ERR_CNT + CW'(1));
      end else if (ERR_CLR) begin
        ERR_CNT <= '0;
      end
    end
  end

  always_comb begin
    HREADYOUT = 1'b1;
    HRESP     = 1'b0;
    HRDATA    = '0;
    unique case (state_q)
      DpIdle: ;
      DpSlave: begin
        HREADYOUT = P_HREADYOUT[sel_q];
        HRESP     = P_HRESP[sel_q];
        HRDATA    = P_HRDATA[sel_q*DW +: DW];
      end
      DpErr1: begin
        HREADYOUT = 1'b0;
        HRESP     = 1'b1;
      end
      DpErr2: HRESP = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_ahblite_slave_mux_n.sv
// Bench for ahblite_slave_mux_n: instance A (MULTI_ERR=1, CW=8) and B (MULTI_ERR=0, CW=2).
module tb_ahblite_slave_mux_n;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         hready_a, hready_b;
  logic [1:0]   htrans;
  logic [3:0]   hsel, p_rdy, p_resp;
  logic [127:0] p_data;
  logic         err_clr;
  logic         rdy_a, resp_a, irq_a, rdy_b, resp_b, irq_b;
  logic [31:0]  data_a, data_b;
  logic [7:0]   cnt_a;
  logic [1:0]   cnt_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ahblite_slave_mux_n #(.NPORT(4), .DW(32), .CW(8), .MULTI_ERR(1'b1)) u_dut_a (
    .HCLK(clk), .HRESETn(rst_n), .HREADY(hready_a), .HTRANS(htrans), .HSEL(hsel),
    .P_HREADYOUT(p_rdy), .P_HRESP(p_resp), .P_HRDATA(p_data), .ERR_CLR(err_clr),
    .HREADYOUT(rdy_a), .HRESP(resp_a), .HRDATA(data_a), .ERR_CNT(cnt_a), .ERR_IRQ(irq_a)
  );

  ahblite_slave_mux_n #(.NPORT(4), .DW(32), .CW(2), .MULTI_ERR(1'b0)) u_dut_b (
    .HCLK(clk), .HRESETn(rst_n), .HREADY(hready_b), .HTRANS(htrans), .HSEL(hsel),
    .P_HREADYOUT(p_rdy), .P_HRESP(p_resp), .P_HRDATA(p_data), .ERR_CLR(err_clr),
    .HREADYOUT(rdy_b), .HRESP(resp_b), .HRDATA(data_b), .ERR_CNT(cnt_b), .ERR_IRQ(irq_b)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: kind 0=idle, 1=routed to slave, 2=error 1st cycle, 3=error 2nd cycle.
  int m_kind[2];
  int m_port[2];
  int m_cnt[2];
  bit m_irq[2];
  int m_max[2]   = '{255, 3};
  bit m_multi[2] = '{1'b1, 1'b0};

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_kind[d] = 0; m_port[d] = 0; m_cnt[d] = 0; m_irq[d] = 1'b0;
    end
  endtask

  function automatic int lowest(input logic [3:0] h);
    for (int k = 0; k < 4; k++) if (h[k]) return k;
    return 0;
  endfunction

  function automatic logic exp_rdy(input int d);
    case (m_kind[d])
      1: return p_rdy[m_port[d]];
      2: return 1'b0;
      default: return 1'b1;
    endcase
  endfunction

  function automatic logic exp_resp(input int d);
    case (m_kind[d])
      1: return p_resp[m_port[d]];
      2, 3: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] exp_data(input int d);
    if (m_kind[d] == 1) return p_data[m_port[d]*32 +: 32];
    return 32'h0;
  endfunction

  task automatic model_step(input int d, input logic hr);
    bit entering = 1'b0;
    int n;
    if (m_kind[d] == 2) begin
      m_kind[d] = 3;
    end else if (m_kind[d] == 3 || (hr && exp_rdy(d))) begin
      n = $countones(hsel);
      if (n == 1 || (n > 1 && !m_multi[d])) begin
        m_kind[d] = 1;
        m_port[d] = lowest(hsel);
      end else if (htrans[1]) begin
        m_kind[d] = 2;
        entering  = 1'b1;
      end else begin
        m_kind[d] = 0;
      end
    end
    if (entering) m_cnt[d] = err_clr ? 1 : (m_cnt[d] < m_max[d] ? m_cnt[d] + 1 : m_max[d]);
    else if (err_clr) m_cnt[d] = 0;
    m_irq[d] = entering;
  endtask

  task automatic check_all();
    chk("rand_hreadyout_a", 32'(rdy_a), 32'(exp_rdy(0)));
    chk("rand_hresp_a", 32'(resp_a), 32'(exp_resp(0)));
    chk("rand_hrdata_a", data_a, exp_data(0));
    chk("rand_err_cnt_a", 32'(cnt_a), 32'(m_cnt[0]));
    chk("rand_err_irq_a", 32'(irq_a), 32'(m_irq[0]));
    chk("rand_hreadyout_b", 32'(rdy_b), 32'(exp_rdy(1)));
    chk("rand_hresp_b", 32'(resp_b), 32'(exp_resp(1)));
    chk("rand_hrdata_b", data_b, exp_data(1));
    chk("rand_err_cnt_b", 32'(cnt_b), 32'(m_cnt[1]));
    chk("rand_err_irq_b", 32'(irq_b), 32'(m_irq[1]));
  endtask

  typedef struct {
    logic [3:0]  hsel;
    logic [1:0]  htrans;
    logic        a_rdy, a_resp;
    logic [31:0] a_data;
    logic        b_rdy, b_resp;
    logic [31:0] b_data;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int ca, cb;
    bit ea, eb;

    vecs[0] = '{4'b0100, 2'b10, 1'b1, 1'b0, 32'hA5A5_0002, 1'b1, 1'b0, 32'hA5A5_0002};
    vecs[1] = '{4'b0000, 2'b10, 1'b0, 1'b1, 32'h0,         1'b0, 1'b1, 32'h0};
    vecs[2] = '{4'b0000, 2'b00, 1'b1, 1'b0, 32'h0,         1'b1, 1'b0, 32'h0};
    vecs[3] = '{4'b0011, 2'b10, 1'b0, 1'b1, 32'h0,         1'b1, 1'b0, 32'hA5A5_0000};
    vecs[4] = '{4'b1000, 2'b00, 1'b1, 1'b0, 32'hA5A5_0003, 1'b1, 1'b0, 32'hA5A5_0003};
    vecs[5] = '{4'b1100, 2'b11, 1'b0, 1'b1, 32'h0,         1'b1, 1'b0, 32'hA5A5_0002};

    rst_n = 1'b0; hready_a = 1'b1; hready_b = 1'b1; htrans = 2'b00; hsel = 4'b0;
    p_rdy = 4'hF; p_resp = 4'h0; err_clr = 1'b0;
    for (int k = 0; k < 4; k++) p_data[k*32 +: 32] = 32'hA5A5_0000 + 32'(k);

    #12;
    chk("reset_hreadyout", 32'(rdy_a), 32'h1);
    chk("reset_hresp", 32'(resp_a), 32'h0);
    chk("reset_hrdata", data_a, 32'h0);
    chk("reset_err_cnt", 32'(cnt_a), 32'h0);
    chk("reset_err_irq", 32'(irq_a), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Single transfers from the table, each followed by one idle address phase.
    ca = 0; cb = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      hsel = vecs[i].hsel; htrans = vecs[i].htrans; hready_a = 1'b1; hready_b = 1'b1;
      @(posedge clk);
      @(negedge clk);
      hsel = 4'b0; htrans = 2'b00; hready_a = vecs[i].a_rdy; hready_b = vecs[i].b_rdy;
      ea = vecs[i].a_resp & ~vecs[i].a_rdy;
      eb = vecs[i].b_resp & ~vecs[i].b_rdy;
      if (ea) ca++;
      if (eb && cb < 3) cb++;
      #1;
      chk($sformatf("vec%0d_hreadyout_a", i), 32'(rdy_a), 32'(vecs[i].a_rdy));
      chk($sformatf("vec%0d_hresp_a", i), 32'(resp_a), 32'(vecs[i].a_resp));
      chk($sformatf("vec%0d_hrdata_a", i), data_a, vecs[i].a_data);
      chk($sformatf("vec%0d_err_irq_a", i), 32'(irq_a), 32'(ea));
      chk($sformatf("vec%0d_err_cnt_a", i), 32'(cnt_a), 32'(ca));
      chk($sformatf("vec%0d_hreadyout_b", i), 32'(rdy_b), 32'(vecs[i].b_rdy));
      chk($sformatf("vec%0d_hresp_b", i), 32'(resp_b), 32'(vecs[i].b_resp));
      chk($sformatf("vec%0d_hrdata_b", i), data_b, vecs[i].b_data);
      chk($sformatf("vec%0d_err_cnt_b", i), 32'(cnt_b), 32'(cb));
      @(posedge clk);
      @(negedge clk);
      hready_a = 1'b1; hready_b = 1'b1;
      #1;
      chk($sformatf("vec%0d_2nd_hreadyout_a", i), 32'(rdy_a), 32'h1);
      chk($sformatf("vec%0d_2nd_hresp_a", i), 32'(resp_a), 32'(ea));
      chk($sformatf("vec%0d_2nd_err_irq_a", i), 32'(irq_a), 32'h0);
      chk($sformatf("vec%0d_2nd_hresp_b", i), 32'(resp_b), 32'(eb));
    end

    // Port 1 stalls three cycles while the decoder already points at port 0.
    @(negedge clk);
    hsel = 4'b0010; htrans = 2'b10; hready_a = 1'b1; hready_b = 1'b1;
    @(posedge clk);
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      p_rdy = 4'b1101; hsel = 4'b0001; hready_a = 1'b0; hready_b = 1'b0;
      #1;
      chk($sformatf("stall%0d_hreadyout_a", j), 32'(rdy_a), 32'h0);
      chk($sformatf("stall%0d_hreadyout_b", j), 32'(rdy_b), 32'h0);
      @(posedge clk);
    end
    @(negedge clk);
    p_rdy = 4'hF; hready_a = 1'b1; hready_b = 1'b1;
    #1;
    chk("stall_release_hreadyout", 32'(rdy_a), 32'h1);
    chk("stall_release_hrdata", data_a, 32'hA5A5_0001);
    @(posedge clk);
    @(negedge clk);
    hsel = 4'b0; htrans = 2'b00;
    #1;
    chk("after_stall_hrdata", data_a, 32'hA5A5_0000);

    // Back-to-back unmapped transfers: saturation on B, clear-with-entry on the 6th.
    @(negedge clk);
    err_clr = 1'b1;
    @(posedge clk);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      hsel = 4'b0; htrans = 2'b10; hready_a = 1'b1; hready_b = 1'b1; err_clr = (i == 5);
      @(posedge clk);
      #1;
      chk($sformatf("sat%0d_err_cnt_a", i), 32'(cnt_a), (i == 5) ? 32'd1 : 32'(i + 1));
      chk($sformatf("sat%0d_err_cnt_b", i), 32'(cnt_b),
          (i == 5) ? 32'd1 : ((i + 1 > 3) ? 32'd3 : 32'(i + 1)));
      chk($sformatf("sat%0d_err_irq_b", i), 32'(irq_b), 32'h1);
      chk($sformatf("sat%0d_err1_resp", i), 32'({rdy_b, resp_b}), 32'b01);
      @(negedge clk);
      hready_a = 1'b0; hready_b = 1'b0; err_clr = 1'b0;
      @(posedge clk);
      #1;
      chk($sformatf("sat%0d_err2_resp", i), 32'({rdy_b, resp_b}), 32'b11);
      chk($sformatf("sat%0d_err2_irq", i), 32'(irq_b), 32'h0);
    end
    @(negedge clk);
    htrans = 2'b00; hready_a = 1'b1; hready_b = 1'b1;
    @(posedge clk);

    // Asynchronous reset while in the first error cycle.
    @(negedge clk);
    htrans = 2'b10;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_err1_hreadyout", 32'(rdy_a), 32'h1);
    chk("rst_err1_hresp", 32'(resp_a), 32'h0);
    chk("rst_err1_irq", 32'(irq_a), 32'h0);
    chk("rst_err1_cnt_a", 32'(cnt_a), 32'h0);
    chk("rst_err1_cnt_b", 32'(cnt_b), 32'h0);
    @(negedge clk);
    htrans = 2'b00;
    rst_n = 1'b1;
    model_reset();

    // Randomised traffic against the reference model.
    for (int c = 0; c < 1500; c++) begin
      int r;
      @(negedge clk);
      r = $urandom_range(0, 3);
      if (r == 0) hsel = 4'b0;
      else if (r == 3) hsel = 4'($urandom());
      else hsel = 4'b0001 << $urandom_range(0, 3);
      htrans = 2'($urandom());
      for (int k = 0; k < 4; k++) p_rdy[k] = ($urandom_range(0, 3) != 0);
      p_resp = 4'($urandom()) & 4'($urandom());
      p_data = {$urandom(), $urandom(), $urandom(), $urandom()};
      err_clr = ($urandom_range(0, 19) == 0);
      hready_a = exp_rdy(0);
      if (m_kind[0] < 2 && $urandom_range(0, 9) == 0) hready_a = 1'b0;
      hready_b = exp_rdy(1);
      if (m_kind[1] < 2 && $urandom_range(0, 9) == 0) hready_b = 1'b0;
      #1;
      check_all();
      @(posedge clk);
      model_step(0, hready_a);
      model_step(1, hready_b);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
